dmac_ioregister_initiator: RTL and testbench

Initiator-side engine for the DMAC I/O-register channel. It drives the address channel (`ext_addr` / `ext_read_enable` / `ext_write_enable` / `ext_word_size` / `ext_ready`) and the opposite ends of the two transparent data FIFOs: it enqueues write data and dequeues read data. It accepts one transfer command from user logic at a time and splits it into bursts that never exceed MAX_BURST_LEN words and never cross a 2^W_BOUNDARY_A-byte boundary. It sits in the user-clock domain, between user logic and a DMAC-side responder.

---
 rtl/dmac_ioregister_initiator_if.sv | 67 ++++++
 rtl/dmac_ioregister_initiator.sv | 146 ++++++++++++++
 tb/tb_dmac_ioregister_initiator.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmac_ioregister_initiator_if.sv
// Bus bundle for the DMAC I/O-register initiator: command port, address
// channel, write-data stream/FIFO push side, read-FIFO pop side/read stream.
interface dmac_ioregister_initiator_if #(
    parameter int W_D     = 32,
    parameter int W_EXT_A = 32,
    parameter int W_BLEN  = 9
);
    logic [W_EXT_A-1:0] cmd_addr;
    logic [W_EXT_A-1:0] cmd_size;
    logic               cmd_write;
    logic               cmd_valid;
    logic               cmd_ready;
    logic               busy;
    logic               done;

    logic [W_EXT_A-1:0] ext_addr;
    logic               ext_read_enable;
    logic               ext_write_enable;
    logic [W_BLEN-1:0]  ext_word_size;
    logic               ext_ready;

    logic [W_D-1:0]     src_data;
    logic               src_valid;
    logic               src_ready;

    logic [W_D-1:0]     ext_write_data;
    logic               ext_write_enq;
    logic               ext_write_almost_full;

    logic [W_D-1:0]     ext_read_data;
    logic               ext_read_deq;
    logic               ext_read_empty;

    logic [W_D-1:0]     dst_data;
    logic               dst_valid;
    logic               dst_ready;

    modport master (
        input  cmd_addr, cmd_size, cmd_write, cmd_valid,
        output cmd_ready, busy, done,
        output ext_addr, ext_read_enable, ext_write_enable, ext_word_size,
        input  ext_ready,
        input  src_data, src_valid,
        output src_ready,
        output ext_write_data, ext_write_enq,
        input  ext_write_almost_full,
        input  ext_read_data, ext_read_empty,
        output ext_read_deq,
        output dst_data, dst_valid,
        input  dst_ready
    );

    modport slave (
        output cmd_addr, cmd_size, cmd_write, cmd_valid,
        input  cmd_ready, busy, done,
        input  ext_addr, ext_read_enable, ext_write_enable, ext_word_size,
        output ext_ready,
        output src_data, src_valid,
        input  src_ready,
        input  ext_write_data, ext_write_enq,
        output ext_write_almost_full,
        output ext_read_data, ext_read_empty,
        input  ext_read_deq,
        input  dst_data, dst_valid,
        output dst_ready
    );
endinterface

// File: rtl/dmac_ioregister_initiator.sv
// DMAC I/O-register initiator: takes one transfer command at a time, splits
// it into bursts limited by MAX_BURST_LEN and the 2^W_BOUNDARY_A-byte line,
// issues each burst on the address channel and moves the data words.
module dmac_ioregister_initiator #(
    parameter int W_D           = 32,
    parameter int W_EXT_A       = 32,
    parameter int W_BOUNDARY_A  = 12,
    parameter int W_BLEN        = 9,
    parameter int MAX_BURST_LEN = 256
) (
    input  logic i_clk,
    input  logic i_rst,
    dmac_ioregister_initiator_if.master bus
);
    localparam int BYTES = W_D / 8;
    localparam int ALIGN = $clog2(BYTES);
    // one bit wider than the boundary so a full line is representable
    localparam int WC    = W_BOUNDARY_A + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_ADDR = 2'd2;
    localparam logic [1:0] S_DATA = 2'd3;

    logic [1:0]         r_state;
    logic [W_EXT_A-1:0] r_addr;
    logic [W_EXT_A-1:0] r_remaining;
    logic               r_write;
    logic [W_BLEN-1:0]  r_blen;
    logic [W_BLEN-1:0]  r_beat;
    logic [W_EXT_A-1:0] r_ext_addr;
    logic [W_BLEN-1:0]  r_ext_word_size;
    logic               r_wen;
    logic               r_ren;
    logic               r_done;
    logic               r_busy;

    logic [WC-1:0]      w_line_bytes;
    logic [WC-1:0]      w_line_words;
    logic [WC-1:0]      w_cap;
    logic [W_BLEN-1:0]  w_blen;
    logic [W_EXT_A-1:0] w_align_mask;
    logic [W_EXT_A-1:0] w_burst_bytes;
    logic               w_in_data;
    logic               w_wr_go;
    logic               w_rd_valid;
    logic               w_rd_go;
    logic               w_xfer;

    // burst length: min(remaining, MAX_BURST_LEN, words left in the line)
    assign w_align_mask  = ~(W_EXT_A'(BYTES - 1));
    assign w_line_bytes  = (WC'(1) << W_BOUNDARY_A) - {1'b0, r_addr[W_BOUNDARY_A-1:0]};
    assign w_line_words  = w_line_bytes >> ALIGN;
    assign w_cap         = (w_line_words < WC'(MAX_BURST_LEN)) ? w_line_words : WC'(MAX_BURST_LEN);
    assign w_blen        = (r_remaining < W_EXT_A'(w_cap)) ? W_BLEN'(r_remaining) : W_BLEN'(w_cap);
    assign w_burst_bytes = W_EXT_A'(r_blen) << ALIGN;

    // data movement is only allowed once the burst request was accepted
    assign w_in_data  = (r_state == S_DATA);
    assign w_wr_go    = w_in_data && r_write && bus.src_valid && !bus.ext_write_almost_full;
    assign w_rd_valid = w_in_data && !r_write && !bus.ext_read_empty;
    assign w_rd_go    = w_rd_valid && bus.dst_ready;
    assign w_xfer     = w_wr_go || w_rd_go;

    assign bus.cmd_ready        = (r_state == S_IDLE);
    assign bus.busy             = r_busy;
    assign bus.done             = r_done;
    assign bus.ext_addr         = r_ext_addr;
    assign bus.ext_word_size    = r_ext_word_size;
    assign bus.ext_write_enable = r_wen;
    assign bus.ext_read_enable  = r_ren;
    assign bus.src_ready        = w_wr_go;
    assign bus.ext_write_enq    = w_wr_go;
    assign bus.ext_write_data   = bus.src_data;
    assign bus.dst_valid        = w_rd_valid;
    assign bus.dst_data         = bus.ext_read_data;
    assign bus.ext_read_deq     = w_rd_go;

    // command/burst sequencer with word and burst counters
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state         <= S_IDLE;
            r_addr          <= '0;
            r_remaining     <= '0;
            r_write         <= 1'b0;
            r_blen          <= '0;
            r_beat          <= '0;
            r_ext_addr      <= '0;
            r_ext_word_size <= '0;
            r_wen           <= 1'b0;
            r_ren           <= 1'b0;
            r_done          <= 1'b0;
            r_busy          <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        r_addr      <= bus.cmd_addr & w_align_mask;
                        r_remaining <= bus.cmd_size;
                        r_write     <= bus.cmd_write;
                        if (bus.cmd_size == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= S_CALC;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                S_CALC: begin
                    r_blen          <= w_blen;
                    r_ext_addr      <= r_addr;
                    r_ext_word_size <= w_blen;
                    r_wen           <= r_write;
                    r_ren           <= !r_write;
                    r_state         <= S_ADDR;
                end
                S_ADDR: begin
                    if (bus.ext_ready) begin
                        r_wen   <= 1'b0;
                        r_ren   <= 1'b0;
                        r_beat  <= r_blen;
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_xfer) begin
                        r_beat      <= r_beat - W_BLEN'(1);
                        r_remaining <= r_remaining - W_EXT_A'(1);
                        if (r_beat == W_BLEN'(1)) begin
                            r_addr <= r_addr + w_burst_bytes;
                            if (r_remaining == W_EXT_A'(1)) begin
                                r_state <= S_IDLE;
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                            end else begin
                                r_state <= S_CALC;
                            end
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmac_ioregister_initiator.sv
// Randomized bench for dmac_ioregister_initiator with a transaction-level
// reference model stepped once per clock from the stimulus process.
module tb_dmac_ioregister_initiator;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmac_ioregister_initiator_if #(.W_D(32), .W_EXT_A(32), .W_BLEN(9)) bus ();

    dmac_ioregister_initiator #(
        .W_D(32), .W_EXT_A(32), .W_BOUNDARY_A(12), .W_BLEN(9), .MAX_BURST_LEN(256)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    typedef struct {
        logic [31:0] a;
        int          n;
    } burst_t;

    int total = 0;
    int bad   = 0;

    // reference model state
    burst_t bq[$];
    burst_t blog[$];
    bit  chk_en;
    bit  m_active, m_write, m_req, m_done_pend;
    int  m_cd, m_owed, m_rem, m_widx, m_ridx;
    int  enq_cnt, deq_cnt, done_cnt, en_cnt, stab_cnt, af_leak;

    // stimulus state
    logic [31:0] wdat[$];
    logic [31:0] rdat[$];
    int  w_idx, r_idx, p_stall;
    int  af_at, af_left, erdy_left;
    bit  force_af, force_erdy_low;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // burst list from the splitting rule, addresses wrap at 2^32
    task automatic split(input logic [31:0] addr, input int sz);
        logic [31:0] a;
        int rem, line, n;
        a   = addr & 32'hFFFF_FFFC;
        rem = sz;
        while (rem > 0) begin
            line = (4096 - int'(a & 32'hFFF)) / 4;
            n    = rem;
            if (n > 256)  n = 256;
            if (n > line) n = line;
            bq.push_back('{a, n});
            a   = a + 32'(n * 4);
            rem = rem - n;
        end
    endtask

    task automatic model_clear();
        m_active = 0; m_write = 0; m_req = 0; m_done_pend = 0;
        m_cd = 0; m_owed = 0; m_rem = 0; m_widx = 0; m_ridx = 0;
        bq.delete();
    endtask

    // one clock of the model: compare outputs, then apply this cycle's events
    task automatic model_step();
        bit idle0, ed, esr, edv, edq;
        idle0 = !m_active;
        if (m_cd > 0) begin
            m_cd--;
            if (m_cd == 0) m_req = 1;
        end
        ed  = (m_owed > 0);
        esr = ed && m_write && bus.src_valid && !bus.ext_write_almost_full;
        edv = ed && !m_write && !bus.ext_read_empty;
        edq = edv && bus.dst_ready;

        chk("cmd_ready", bus.cmd_ready, !m_active);
        chk("busy", bus.busy, m_active);
        chk("done", bus.done, m_done_pend);
        chk("wr_enable", bus.ext_write_enable, m_req && m_write);
        chk("rd_enable", bus.ext_read_enable, m_req && !m_write);
        chk("src_ready", bus.src_ready, esr);
        chk("write_enq", bus.ext_write_enq, esr);
        chk("dst_valid", bus.dst_valid, edv);
        chk("read_deq", bus.ext_read_deq, edq);
        if (m_req && bq.size() > 0) begin
            chk("ext_addr", bus.ext_addr, bq[0].a);
            chk("word_size", bus.ext_word_size, bq[0].n);
        end
        if (bus.done) done_cnt++;
        if (bus.ext_write_enable || bus.ext_read_enable) en_cnt++;
        if (bus.ext_write_enable && bus.ext_addr == 32'h2000 && bus.ext_word_size == 9'd2) stab_cnt++;
        if (bus.ext_write_almost_full && (bus.src_ready || bus.ext_write_enq)) af_leak++;
        m_done_pend = 0;

        if (esr) begin
            chk("write_data", bus.ext_write_data, wdat[m_widx]);
            m_widx++;
            enq_cnt++;
        end
        if (edq) begin
            chk("dst_data", bus.dst_data, rdat[m_ridx]);
            m_ridx++;
            deq_cnt++;
        end
        if (esr || edq) begin
            m_owed--;
            m_rem--;
            if (m_owed == 0) begin
                if (m_rem == 0) begin
                    m_active    = 0;
                    m_done_pend = 1;
                end else begin
                    m_cd = 2;
                end
            end
        end
        if (m_req && bus.ext_ready && bq.size() > 0) begin
            blog.push_back(bq[0]);
            m_owed = bq[0].n;
            bq.pop_front();
            m_req = 0;
        end
        if (idle0 && bus.cmd_valid) begin
            split(bus.cmd_addr, int'(bus.cmd_size));
            m_rem   = int'(bus.cmd_size);
            m_write = bus.cmd_write;
            m_widx  = 0;
            m_ridx  = 0;
            if (bus.cmd_size == 0) m_done_pend = 1;
            else begin
                m_active = 1;
                m_cd     = 2;
            end
        end
    endtask

    task automatic drive();
        bit st;
        bus.src_valid = (w_idx < wdat.size()) && ($urandom_range(0, 3) >= p_stall);
        bus.src_data  = (w_idx < wdat.size()) ? wdat[w_idx] : $urandom;
        bus.ext_write_almost_full = force_af || ($urandom_range(0, 3) < p_stall);
        st = ($urandom_range(0, 3) < p_stall);
        bus.ext_read_empty = (r_idx >= rdat.size()) || st;
        bus.ext_read_data  = (r_idx < rdat.size()) ? rdat[r_idx] : $urandom;
        bus.dst_ready = ($urandom_range(0, 3) >= p_stall);
        bus.ext_ready = !force_erdy_low && ($urandom_range(0, 3) >= p_stall);
    endtask

    task automatic cycle();
        bit shs, rhs, chs;
        @(negedge clk);
        if (chk_en) model_step();
        shs = bus.src_valid && bus.src_ready;
        rhs = bus.ext_read_deq;
        chs = bus.cmd_valid && bus.cmd_ready;
        @(posedge clk);
        #1;
        if (shs) w_idx++;
        if (rhs) r_idx++;
        if (chs) bus.cmd_valid = 1'b0;
        if (af_left > 0 && enq_cnt >= af_at) begin
            force_af = 1;
            af_left--;
        end else force_af = 0;
        force_erdy_low = (erdy_left > 0);
        if (erdy_left > 0) erdy_left--;
        drive();
    endtask

    task automatic start_cmd(input logic [31:0] a, input int sz, input bit wr, input bit seqd);
        logic [31:0] v;
        wdat.delete();
        rdat.delete();
        w_idx = 0; r_idx = 0;
        for (int i = 0; i < sz; i++) begin
            v = seqd ? 32'(i + 1) : $urandom;
            if (wr) wdat.push_back(v);
            else    rdat.push_back(v);
        end
        blog.delete();
        enq_cnt = 0; deq_cnt = 0; done_cnt = 0; en_cnt = 0; stab_cnt = 0; af_leak = 0;
        bus.cmd_addr  = a;
        bus.cmd_size  = 32'(sz);
        bus.cmd_write = wr;
        bus.cmd_valid = 1'b1;
        drive();
    endtask

    task automatic run_cmd(input logic [31:0] a, input int sz, input bit wr, input bit seqd);
        int n;
        start_cmd(a, sz, wr, seqd);
        n = 0;
        do begin
            cycle();
            n++;
        end while ((bus.cmd_valid || m_active || m_done_pend) && n < 20000);
        if (n >= 20000) chk("cmd_timeout", 0, 1);
    endtask

    task automatic reset_checks();
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_wr_en", bus.ext_write_enable, 0);
        chk("rst_rd_en", bus.ext_read_enable, 0);
        chk("rst_ext_addr", bus.ext_addr, 0);
        chk("rst_word_size", bus.ext_word_size, 0);
        chk("rst_src_ready", bus.src_ready, 0);
        chk("rst_enq", bus.ext_write_enq, 0);
        chk("rst_dst_valid", bus.dst_valid, 0);
        chk("rst_deq", bus.ext_read_deq, 0);
    endtask

    initial begin
        int n;
        bus.cmd_addr = '0; bus.cmd_size = '0; bus.cmd_write = 1'b0; bus.cmd_valid = 1'b0;
        bus.ext_ready = 1'b0; bus.src_valid = 1'b0; bus.src_data = '0;
        bus.ext_write_almost_full = 1'b0; bus.ext_read_data = '0;
        bus.ext_read_empty = 1'b1; bus.dst_ready = 1'b0;
        p_stall = 0; af_at = 0; af_left = 0; erdy_left = 0;
        force_af = 0; force_erdy_low = 0;
        chk_en = 0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        reset_checks();
        rst = 1'b0;
        chk_en = 1;

        // single 4-word write burst with data 1..4
        run_cmd(32'h1000, 4, 1'b1, 1'b1);
        chk("t1_bursts", blog.size(), 1);
        chk("t1_addr", blog[0].a, 32'h1000);
        chk("t1_len", blog[0].n, 4);
        chk("t1_enq", enq_cnt, 4);
        chk("t1_done", done_cnt, 1);

        // read crossing a 4 KB line
        run_cmd(32'h0FF8, 6, 1'b0, 1'b1);
        chk("t2_bursts", blog.size(), 2);
        chk("t2_a0", blog[0].a, 32'h0FF8);
        chk("t2_n0", blog[0].n, 2);
        chk("t2_a1", blog[1].a, 32'h1000);
        chk("t2_n1", blog[1].n, 4);
        chk("t2_deq", deq_cnt, 6);

        // long read limited by MAX_BURST_LEN, with random stalls
        p_stall = 1;
        run_cmd(32'h0, 600, 1'b0, 1'b0);
        chk("t3_bursts", blog.size(), 3);
        chk("t3_a0", blog[0].a, 32'h000);
        chk("t3_n0", blog[0].n, 256);
        chk("t3_a1", blog[1].a, 32'h400);
        chk("t3_n1", blog[1].n, 256);
        chk("t3_a2", blog[2].a, 32'h800);
        chk("t3_n2", blog[2].n, 88);
        chk("t3_deq", deq_cnt, 600);
        chk("t3_done", done_cnt, 1);

        // write with almost_full held for 5 cycles mid-burst
        p_stall = 0;
        af_at = 3; af_left = 5;
        run_cmd(32'h500, 8, 1'b1, 1'b1);
        chk("t4_enq", enq_cnt, 8);
        chk("t4_af_leak", af_leak, 0);
        chk("t4_af_used", af_left, 0);

        // zero-size command
        run_cmd(32'h1234, 0, 1'b1, 1'b0);
        chk("t5_bursts", blog.size(), 0);
        chk("t5_done", done_cnt, 1);
        chk("t5_enables", en_cnt, 0);

        // request held while ext_ready stays low
        erdy_left = 12;
        run_cmd(32'h2000, 2, 1'b1, 1'b0);
        chk("t6_stable", stab_cnt >= 10, 1);
        chk("t6_enq", enq_cnt, 2);

        // reset after the 3rd word of a 16-word read
        p_stall = 1;
        start_cmd(32'h40, 16, 1'b0, 1'b0);
        n = 0;
        while (deq_cnt < 3 && n < 2000) begin
            cycle();
            n++;
        end
        chk("t7_reached", deq_cnt >= 3, 1);
        rst = 1'b1;
        chk_en = 0;
        #1;
        reset_checks();
        model_clear();
        bus.cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1;
        p_stall = 0;
        run_cmd(32'h3004, 5, 1'b1, 1'b0);
        chk("t7_enq", enq_cnt, 5);
        chk("t7_done", done_cnt, 1);
        chk("t7_addr", blog[0].a, 32'h3004);
        chk("t7_len", blog[0].n, 5);

        // random commands
        for (int k = 0; k < 30; k++) begin
            logic [31:0] a;
            int sz, sel;
            sel = $urandom_range(0, 3);
            case (sel)
                0: a = $urandom;
                1: a = (32'($urandom_range(1, 200)) << 12) - 32'($urandom_range(0, 64));
                2: a = 32'hFFFF_F000 + 32'($urandom_range(0, 4095));
                default: a = 32'($urandom_range(0, 65535));
            endcase
            sz = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 400);
            p_stall = $urandom_range(0, 2);
            run_cmd(a, sz, 1'($urandom_range(0, 1)), 1'b0);
            chk("rnd_done", done_cnt, 1);
            chk("rnd_words", enq_cnt + deq_cnt, sz);
        end

        repeat (3) cycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
